// File: rtl/alu_adder_dmem.sv
// Execution/memory slice of the single-cycle MIPS datapath: 32-bit ALU,
// a stand-alone 32-bit adder for PC math, and a word-addressed data memory.
module alu_adder_dmem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        alu_ovf,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] add_sum,
    output logic        add_ovf,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADDU = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_ADD  = 4'b1010,
        OP_SUBS = 4'b1110,
        OP_SLTU = 4'b1111
    } alu_op_e;

    logic [31:0]       w_sum;
    logic [31:0]       w_diff;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_addr;
    logic [31:0]       r_mem [DEPTH];

    assign w_sum  = alu_a + alu_b;
    assign w_diff = alu_a - alu_b;

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ADDU: alu_result = w_sum;
            OP_SLL:  alu_result = alu_b << alu_a[4:0];
            OP_SRL:  alu_result = alu_b >> alu_a[4:0];
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SUB:  alu_result = w_diff;
            OP_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            OP_ADD: begin
                alu_result = w_sum;
                alu_ovf    = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
            end
            OP_SUBS: begin
                alu_result = w_diff;
                alu_ovf    = (alu_a[31] != alu_b[31]) && (w_diff[31] != alu_a[31]);
            end
            OP_SLTU: alu_result = {31'b0, alu_a < alu_b};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    assign add_sum = add_a + add_b;
    assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

    // Upper address bits are deliberately dropped so addresses wrap.
    assign w_idx         = mem_addr[ADDR_W-1:0];
    assign w_unused_addr = &{1'b0, mem_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_write) begin
            r_mem[w_idx] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_read ? r_mem[w_idx] : 32'd0;

endmodule

// File: tb/tb_alu_adder_dmem.sv
// Directed self-checking bench for alu_adder_dmem; expected values are queued
// on a scoreboard when stimulus is applied and popped when outputs are sampled.
module tb_alu_adder_dmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf;
    logic [31:0] add_a = '0;
    logic [31:0] add_b = '0;
    logic [31:0] add_sum;
    logic        add_ovf;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_rdata;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    alu_adder_dmem #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ovf(add_ovf),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic expectVal(input string tag, input logic [31:0] val);
        sb_item_t item;
        item.tag = tag;
        item.val = val;
        sb.push_back(item);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        sb_item_t item;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.val) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %h expected %h", item.tag, obs, item.val);
            end
        end
    endtask

    task automatic aluStep(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] ctrl, input logic [31:0] expRes,
                           input logic expZero, input logic expOvf);
        expectVal({tag, "_res"}, expRes);
        expectVal({tag, "_zero"}, {31'b0, expZero});
        expectVal({tag, "_ovf"}, {31'b0, expOvf});
        alu_a = a; alu_b = b; alu_ctrl = ctrl;
        #1;
        checkOutput(alu_result);
        checkOutput({31'b0, alu_zero});
        checkOutput({31'b0, alu_ovf});
    endtask

    task automatic addStep(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expSum, input logic expOvf);
        expectVal({tag, "_sum"}, expSum);
        expectVal({tag, "_ovf"}, {31'b0, expOvf});
        add_a = a; add_b = b;
        #1;
        checkOutput(add_sum);
        checkOutput({31'b0, add_ovf});
    endtask

    task automatic readStep(input string tag, input logic [31:0] addr, input logic rd,
                            input logic [31:0] expData);
        expectVal(tag, expData);
        mem_addr = addr; mem_read = rd;
        #1;
        checkOutput(mem_rdata);
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr = addr; mem_wdata = data; mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        readStep("reset_rdata", 32'd3, 1'b1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        readStep("post_reset_rdata", 32'd5, 1'b1, 32'd0);

        aluStep("and",  32'h0000000F, 32'h000000F0, 4'b0000, 32'h0, 1'b1, 1'b0);
        aluStep("or",   32'h0000000F, 32'h000000F0, 4'b0001, 32'hFF, 1'b0, 1'b0);
        aluStep("xor",  32'h0000000F, 32'h000000F0, 4'b0101, 32'hFF, 1'b0, 1'b0);
        aluStep("sub",  32'd5, 32'd5, 4'b0110, 32'h0, 1'b1, 1'b0);
        aluStep("sub_wrap", 32'h80000000, 32'd1, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b0);
        aluStep("sll",  32'd4, 32'd1, 4'b0011, 32'h10, 1'b0, 1'b0);
        aluStep("sll_mask", 32'h00000024, 32'd1, 4'b0011, 32'h10, 1'b0, 1'b0);
        aluStep("srl",  32'd4, 32'h80000000, 4'b0100, 32'h08000000, 1'b0, 1'b0);
        aluStep("slt",  32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0);
        aluStep("slt_false", 32'd1, 32'hFFFFFFFF, 4'b0111, 32'd0, 1'b1, 1'b0);
        aluStep("sltu", 32'hFFFFFFFF, 32'd1, 4'b1111, 32'd0, 1'b1, 1'b0);
        aluStep("sltu_true", 32'd1, 32'hFFFFFFFF, 4'b1111, 32'd1, 1'b0, 1'b0);
        aluStep("add_ovf",  32'h7FFFFFFF, 32'd1, 4'b1010, 32'h80000000, 1'b0, 1'b1);
        aluStep("add_noovf", 32'hFFFFFFFF, 32'd1, 4'b1010, 32'h0, 1'b1, 1'b0);
        aluStep("addu", 32'h7FFFFFFF, 32'd1, 4'b0010, 32'h80000000, 1'b0, 1'b0);
        aluStep("subs_ovf", 32'h80000000, 32'd1, 4'b1110, 32'h7FFFFFFF, 1'b0, 1'b1);
        aluStep("subs_noovf", 32'd3, 32'd5, 4'b1110, 32'hFFFFFFFE, 1'b0, 1'b0);
        aluStep("undef", 32'h12345678, 32'h9ABCDEF0, 4'b1001, 32'h0, 1'b1, 1'b0);

        addStep("adder_inc",  32'h00000010, 32'd1, 32'h11, 1'b0);
        addStep("adder_ovf",  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1);
        addStep("adder_wrap", 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
        addStep("adder_negovf", 32'h80000000, 32'h80000000, 32'h0, 1'b1);

        writeWord(32'd3, 32'hDEADBEEF);
        readStep("mem_rd3", 32'd3, 1'b1, 32'hDEADBEEF);
        readStep("mem_rd_disabled", 32'd3, 1'b0, 32'd0);
        readStep("mem_rd_wrap", 32'h103, 1'b1, 32'hDEADBEEF);
        readStep("mem_rd_other", 32'd4, 1'b1, 32'd0);

        writeWord(32'd7, 32'h11);
        @(negedge clk);
        mem_addr = 32'd7; mem_wdata = 32'h22; mem_write = 1'b1; mem_read = 1'b1;
        expectVal("rdw_before", 32'h11);
        #1 checkOutput(mem_rdata);
        @(posedge clk);
        expectVal("rdw_after", 32'h22);
        #1 checkOutput(mem_rdata);
        mem_write = 1'b0;

        for (int i = 0; i < 4; i++) begin
            writeWord(i, 32'hA5A50000 + i);
        end
        readStep("fill_check2", 32'd2, 1'b1, 32'hA5A50002);
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            readStep($sformatf("reset_clear%0d", i), i, 1'b1, 32'd0);
        end
        readStep("reset_clear7", 32'd7, 1'b1, 32'd0);

        @(negedge clk);
        rst_n = 1'b0;
        mem_addr = 32'd5; mem_wdata = 32'hCAFEF00D; mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        readStep("write_in_reset", 32'd5, 1'b1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        writeWord(32'd5, 32'h0BADCAFE);
        readStep("write_after_release", 32'd5, 1'b1, 32'h0BADCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_adder_dmem.md
# alu_adder_dmem

Datapath execution/memory slice for the single-cycle MIPS core. Bundles the 32-bit ALU, the 32-bit adder used for PC increment and branch-target computation, and the word-addressed data memory. ALU and adder are purely combinational. The memory has an asynchronous read port and a synchronous write port, and is cleared by reset.

## Interface
Parameters:
- `ADDR_W`, default 8: data-memory word-address width.
- `DEPTH`, default 256: number of 32-bit words; must equal 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; memory writes on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `alu_a`  in  32: operand A (rs value).
- `alu_b`  in  32: operand B (rt value or sign-extended immediate).
- `alu_ctrl`  in  4: operation select.
- `alu_result`  out  32: ALU result.
- `alu_zero`  out  1: high when `alu_result` == 0.
- `alu_ovf`  out  1: signed overflow, for signed add/sub codes only.
- `add_a`  in  32: adder operand A.
- `add_b`  in  32: adder operand B.
- `add_sum`  out  32: (add_a + add_b) mod 2^32.
- `add_ovf`  out  1: two's-complement overflow of `add_a + add_b`.
- `mem_addr`  in  32: word address; only bits [ADDR_W-1:0] are used.
- `mem_wdata`  in  32: write data.
- `mem_read`  in  1: read enable.
- `mem_write`  in  1: write enable.
- `mem_rdata`  out  32: read data.

## Operation
ALU (`alu_ctrl` → `alu_result`):
- 0000 AND: A & B.
- 0001 OR: A | B.
- 0010 ADDU: A + B; `alu_ovf` = 0.
- 0011 SLL: B << A[4:0].
- 0100 SRL: B >> A[4:0], logical (zero-fill).
- 0101 XOR: A ^ B.
- 0110 SUB: A − B; `alu_ovf` = 0.
- 0111 SLT: 1 if signed(A) < signed(B), else 0.
- 1010 ADD: signed A + B; `alu_ovf` = 1 when both operands have the same sign and the result sign differs.
- 1110 SUBS: signed A − B; `alu_ovf` = 1 when operand signs differ and the result sign differs from A.
- 1111 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
- Any other code: result = 0, `alu_ovf` = 0, so `alu_zero` = 1.
- `alu_zero` is derived from the final result for every code.
- All arithmetic wraps modulo 2^32.

Adder:
- `add_sum` = A + B, wrapping.
- `add_ovf` = (A[31] == B[31]) && (sum[31] != A[31]).

Data memory:
- Storage: DEPTH × 32-bit words, word-addressed. Index = `mem_addr[ADDR_W-1:0]`; upper address bits are ignored, so addresses wrap.
- Read: `mem_rdata` = mem[index] while `mem_read` = 1; `mem_rdata` = 0 while `mem_read` = 0.
- Write: at posedge `clk`, if `mem_write` = 1 and `rst_n` = 1, mem[index] ← `mem_wdata`.
- Simultaneous read and write to the same index: before the edge `mem_rdata` shows the old word; after the edge it shows the new word.
- `rst_n` low clears every word to 0 asynchronously. Writes are ignored while reset is asserted.

## Timing
- ALU and adder outputs: zero latency (combinational); they do not depend on the clock or reset.
- Memory read: combinational from `mem_addr` / `mem_read` / stored contents; no clock latency.
- Memory write: takes effect at the rising edge; visible on `mem_rdata` in the same cycle, immediately after that edge.
- Reset values:
  - `mem_rdata` = 0 during and after reset, regardless of `mem_read`, until a write occurs.
  - ALU and adder outputs follow their inputs, including during reset.
- Reset asserted mid-cycle: contents clear immediately.
- A write whose edge coincides with `rst_n` low is discarded.
- Release of reset is synchronous-safe: the first write is accepted at the first rising edge with `rst_n` high.

## Test plan
- ALU sweep:
  - A=0x0000000F, B=0x000000F0: AND → 0, zero=1; OR → 0xFF; XOR → 0xFF.
  - A=5, B=5: SUB → 0, zero=1.
  - A=4, B=1: SLL → 0x10.
  - A=4, B=0x80000000: SRL → 0x08000000.
- Compare and overflow:
  - A=0xFFFFFFFF, B=1: SLT → 1; SLTU → 0.
  - ADD with A=0x7FFFFFFF, B=1 → 0x80000000, ovf=1; ADDU with the same operands → ovf=0.
  - SUBS with A=0x80000000, B=1 → 0x7FFFFFFF, ovf=1.
  - Code 1001 → result 0, zero=1.
- Adder:
  - 0x00000010 + 1 → 0x11, ovf=0.
  - 0x7FFFFFFF + 0x7FFFFFFF → 0xFFFFFFFE, ovf=1.
  - 0xFFFFFFFF + 1 → 0, ovf=0.
- Memory write/read:
  - Write 0xDEADBEEF to addr 3 at one edge; with `mem_read`=1, `mem_rdata` = 0xDEADBEEF.
  - `mem_read`=0 → `mem_rdata` = 0.
  - Read addr 0x103 (wraps to 3) → 0xDEADBEEF.
- Read-during-write: addr 7 holds 0x11; drive write of 0x22 to addr 7 with `mem_read`=1 → `mem_rdata` = 0x11 before the edge and 0x22 after it.
- Reset:
  - Fill addrs 0–3 with nonzero data, pulse `rst_n` low between edges → all reads return 0.
  - Hold `rst_n` low across an edge with `mem_write`=1 → the location stays 0.
